universal_shift_register: RTL and testbench
===========================================

UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

Interface
REQ-001 Parameter: WIDTH, default 8, register and data-port width; SHALL be supported for any value >= 2.
REQ-002 Port: clk  input  1  single clock; all state changes on the rising edge except reset.
REQ-003 Port: reset  input  1  asynchronous, active-low reset; the clock is clk and the reset is asynchronous and active-low.
REQ-004 Port: shift_left  input  1  shift-left (toward MSB) request.
REQ-005 Port: shift_right  input  1  shift-right (toward LSB) request.
REQ-006 Port: parallel_in  input  WIDTH  parallel load data.
REQ-007 Port: parallel_out  output  WIDTH  register contents, driven directly from the state flops with no combinational path from any input.
REQ-008 Port order SHALL be clk, reset, shift_left, shift_right, parallel_in, parallel_out, so positional instantiation works.

Function
REQ-009 Mode SHALL be decoded from {shift_left, shift_right} at each rising clk edge while reset is high.
REQ-010 Mode 00: parallel load; the register SHALL take parallel_in.
REQ-011 Mode 10: shift left; the register SHALL take {q[WIDTH-2:0], fill_l}.
REQ-012 Mode 01: shift right; the register SHALL take {fill_r, q[WIDTH-1:1]}.
REQ-013 Mode 11: both requests asserted; the register SHALL hold its value. This is the defined behaviour for simultaneous requests.
REQ-014 Latency SHALL be one clock: the result of an operation appears on parallel_out after the rising edge that samples it.
REQ-015 Fill bits SHALL be fill_l = 0 and fill_r = 0 unless the rotate feature is compiled in (see Configuration).
REQ-016 Mode inputs and parallel_in SHALL be sampled only at clock edges; changes between edges SHALL have no effect.
REQ-017 Shifts are not saturating: bits shifted out SHALL be discarded (or wrapped under rotate), and there SHALL be no overflow flag.

Reset
REQ-018 reset low SHALL clear parallel_out to all zeros immediately, independent of clk.
REQ-019 Reset SHALL dominate every mode, including a reset asserted mid-operation; no clock edge while reset is low SHALL change the state.
REQ-020 On reset deassertion, the first rising clk edge with reset high SHALL perform the decoded mode.

Configuration
REQ-021 Macro USR_ROTATE_EN SHALL select the fill behaviour.
REQ-022 With USR_ROTATE_EN defined, the register SHALL rotate: fill_l = q[WIDTH-1] and fill_r = q[0].
REQ-023 Without USR_ROTATE_EN, the register SHALL shift logically with zero fill. Load, hold and reset SHALL be identical in both builds.

Verification
REQ-024 reset=0 with parallel_in=E5, then clocks -> parallel_out=00 throughout; reset asserted between edges -> output goes to 00 before the next edge.
REQ-025 reset=1, mode 00, parallel_in=E5, one edge -> 0xE5.
REQ-026 Zero-fill build, starting from E5: left -> CA, right -> 65, left -> CA, left -> 94, right -> 4A.
REQ-027 Rotate build, starting from E5: left -> CB; separately, from E5, right -> F2.
REQ-028 Mode 11 for 3 edges from 0xE5 with parallel_in changing -> 0xE5 held each cycle.
REQ-029 WIDTH=4 instance, load 0x9, left (zero fill) -> 0x2, right -> 0x1.

Source files
------------

// File: rtl/universal_shift_register.sv
// WIDTH-bit universal shift register: parallel load, shift left, shift right, hold.
// Define USR_ROTATE_EN to make the shifts rotate instead of zero-filling.
module universal_shift_register #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_left,
  input  logic             shift_right,
  input  logic [WIDTH-1:0] parallel_in,
  output logic [WIDTH-1:0] parallel_out
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic             fill_l;
  logic             fill_r;

`ifdef USR_ROTATE_EN
  assign fill_l = data_q[WIDTH-1];
  assign fill_r = data_q[0];
`else
  assign fill_l = 1'b0;
  assign fill_r = 1'b0;
`endif

  // Simultaneous left and right requests are resolved as a hold.
  always_comb begin
    data_d = data_q;
    case ({shift_left, shift_right})
      2'b00:   data_d = parallel_in;
      2'b10:   data_d = {data_q[WIDTH-2:0], fill_l};
      2'b01:   data_d = {fill_r, data_q[WIDTH-1:1]};
      default: data_d = data_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) data_q <= '0;
    else        data_q <= data_d;
  end

  assign parallel_out = data_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Randomized self-checking bench for universal_shift_register (8-bit and 4-bit instances)
// against an arithmetic reference model; follows USR_ROTATE_EN like the design.
module tb_universal_shift_register;

`ifdef USR_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       sl8, sr8, sl4, sr4;
  logic [7:0] din8, out8;
  logic [3:0] din4, out4;
  logic [31:0] exp8, exp4;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  universal_shift_register #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .shift_left(sl8), .shift_right(sr8),
    .parallel_in(din8), .parallel_out(out8)
  );

  universal_shift_register #(.WIDTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .shift_left(sl4), .shift_right(sr4),
    .parallel_in(din4), .parallel_out(out4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, got, expv, $time);
    end
  endtask

  // Shifting as multiply/divide by two modulo 2**w; rotation re-inserts the lost bit.
  function automatic logic [31:0] ref_next(input logic [31:0] q, input int w,
                                           input logic l, input logic r,
                                           input logic [31:0] din);
    longint unsigned m, top, qq, res;
    m   = 64'd1 << w;
    top = m / 2;
    qq  = {32'd0, q};
    if (!l && !r)     res = {32'd0, din} % m;
    else if (l && !r) res = (qq * 2) % m + (ROT ? qq / top : 64'd0);
    else if (!l && r) res = qq / 2 + (ROT ? (qq % 2) * top : 64'd0);
    else              res = qq;
    return res[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      exp8 = ref_next(exp8, 8, sl8, sr8, {24'd0, din8});
      exp4 = ref_next(exp4, 4, sl4, sr4, {28'd0, din4});
    end else begin
      exp8 = 32'd0;
      exp4 = 32'd0;
    end
    #1;
  endtask

  task automatic drive8(input logic l, input logic r, input logic [7:0] d);
    sl8 = l; sr8 = r; din8 = d;
  endtask

  initial begin
    reset = 1'b0;
    drive8(1'b0, 1'b0, 8'hE5);
    sl4 = 1'b1; sr4 = 1'b1; din4 = 4'h0;
    exp8 = 32'd0; exp4 = 32'd0;
    #3;
    check("reset_init", {24'd0, out8}, 32'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_clocked", {24'd0, out8}, 32'h00);
    end

    reset = 1'b1;
    tick();
    check("load_e5", {24'd0, out8}, 32'hE5);

`ifndef USR_ROTATE_EN
    drive8(1'b1, 1'b0, 8'h00); tick(); check("zf_left1",  {24'd0, out8}, 32'hCA);
    drive8(1'b0, 1'b1, 8'h00); tick(); check("zf_right1", {24'd0, out8}, 32'h65);
    drive8(1'b1, 1'b0, 8'h00); tick(); check("zf_left2",  {24'd0, out8}, 32'hCA);
    drive8(1'b1, 1'b0, 8'h00); tick(); check("zf_left3",  {24'd0, out8}, 32'h94);
    drive8(1'b0, 1'b1, 8'h00); tick(); check("zf_right2", {24'd0, out8}, 32'h4A);
`else
    drive8(1'b1, 1'b0, 8'h00); tick(); check("rot_left",  {24'd0, out8}, 32'hCB);
    drive8(1'b0, 1'b0, 8'hE5); tick();
    drive8(1'b0, 1'b1, 8'h00); tick(); check("rot_right", {24'd0, out8}, 32'hF2);
`endif

    drive8(1'b0, 1'b0, 8'hE5); tick();
    for (int i = 0; i < 3; i++) begin
      drive8(1'b1, 1'b1, 8'($urandom));
      #2 din8 = 8'($urandom);
      tick();
      check("hold_e5", {24'd0, out8}, 32'hE5);
    end

    // Reset asserted between edges must clear the output before the next edge.
    drive8(1'b0, 1'b0, 8'h3C); tick();
    #2 reset = 1'b0;
    #1 check("reset_midcycle", {24'd0, out8}, 32'h00);
    exp8 = 32'd0; exp4 = 32'd0;
    drive8(1'b0, 1'b0, 8'hE5); tick();
    check("reset_edge_ignored", {24'd0, out8}, 32'h00);
    reset = 1'b1;
    drive8(1'b0, 1'b0, 8'h5A); tick();
    check("first_edge_after_reset", {24'd0, out8}, 32'h5A);

    drive8(1'b1, 1'b1, 8'h00);
    sl4 = 1'b0; sr4 = 1'b0; din4 = 4'h9; tick();
    check("w4_load", {28'd0, out4}, 32'h9);
    sl4 = 1'b1; sr4 = 1'b0; tick();
    check("w4_left", {28'd0, out4}, ROT ? 32'h3 : 32'h2);
    sl4 = 1'b0; sr4 = 1'b1; tick();
    check("w4_right", {28'd0, out4}, ROT ? 32'h9 : 32'h1);
    check("w8_held", {24'd0, out8}, 32'h5A);

    for (int i = 0; i < 400; i++) begin
      drive8(1'($urandom), 1'($urandom), 8'($urandom));
      sl4 = 1'($urandom); sr4 = 1'($urandom); din4 = 4'($urandom);
      #2;
      check("rnd_stable8", {24'd0, out8}, exp8);
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b0;
        #1;
        exp8 = 32'd0; exp4 = 32'd0;
        check("rnd_async8", {24'd0, out8}, 32'h00);
        check("rnd_async4", {28'd0, out4}, 32'h0);
        if ($urandom_range(0, 1) == 1) reset = 1'b1;
      end else if (!reset && $urandom_range(0, 1) == 1) begin
        reset = 1'b1;
      end
      din8 = 8'($urandom);
      din4 = 4'($urandom);
      tick();
      check("rnd8", {24'd0, out8}, exp8);
      check("rnd4", {28'd0, out4}, exp4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
